// File: rtl/phase_ring.sv
// phase_ring: N-phase cyclic sequencer. A one-hot token walks the unmasked
// channels in ascending order (mod NUM_PHASES), holding each phase until its
// ack bit arrives. Completed laps are counted, and a per-phase watchdog parks
// the ring in a sticky FAULT state when an ack never comes.
//
// Handshake: a phase is "offered" while phase[i]=1; it completes on the first
// clock edge where ack[i]=1. The token moves exactly one cycle after that
// edge. Acks on any other bit are ignored.
//
// Optional build macro PHASE_RING_ASSERT_EN embeds concurrent assertions and
// a full-lap cover point; behaviour is identical with or without it.
module phase_ring #(
  parameter int NUM_PHASES = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_PHASES-1:0] skip_mask,
  input  logic [NUM_PHASES-1:0] ack,
  output logic [NUM_PHASES-1:0] phase,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  running,
  output logic                  lap_done,
  output logic [CNT_W-1:0]      lap_count,
  output logic                  fault,
  output logic [1:0]            state_dbg
);

  // Watchdog counter must be able to hold the value TIMEOUT itself.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  lap_q, lap_d;
  logic              lap_done_q, lap_done_d;

  logic              ack_cur;
  logic              any_free;
  logic [IDX_W-1:0]  first_idx;
  logic              nxt_found;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_wrap;

  // Index base+k reduced modulo NUM_PHASES (k never exceeds NUM_PHASES).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                               input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PHASES) s = s - NUM_PHASES;
    return IDX_W'(s);
  endfunction

  assign ack_cur  = ack[idx_q];
  assign any_free = ~(&skip_mask);

  // Lowest unmasked index, used when leaving IDLE.
  always_comb begin
    first_idx = '0;
    for (int k = NUM_PHASES - 1; k >= 0; k--) begin
      if (!skip_mask[k]) first_idx = IDX_W'(k);
    end
  end

  // First unmasked index after the current one, current index tried last.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      if (!nxt_found && !skip_mask[wrap_add(idx_q, k)]) begin
        nxt_found = 1'b1;
        nxt_idx   = wrap_add(idx_q, k);
      end
    end
  end

  // Landing at or below the current index means the token went round.
  assign nxt_wrap = (nxt_idx <= idx_q);

  // Next-state logic: phase advance, lap accounting and watchdog.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    lap_d      = lap_q;
    lap_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        wd_d  = '0;
        if (enable && any_free) begin
          state_d = S_RUN;
          idx_d   = first_idx;
        end
      end
      S_RUN: begin
        if (ack_cur) begin
          // Ack beats watchdog expiry in the same cycle.
          wd_d = '0;
          if (enable && nxt_found) begin
            idx_d = nxt_idx;
            if (nxt_wrap) begin
              lap_done_d = 1'b1;
              lap_d      = lap_q + CNT_W'(1);
            end
          end else begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end else if (TIMEOUT > 0) begin
          if (wd_q == WD_W'(TIMEOUT)) begin
            state_d = S_FAULT;
            idx_d   = '0;
            wd_d    = '0;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      S_FAULT: begin
        idx_d = '0;
        wd_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        wd_d    = '0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wd_q       <= '0;
      lap_q      <= '0;
      lap_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      lap_q      <= lap_d;
      lap_done_q <= lap_done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    running   = (state_q == S_RUN);
    phase     = '0;
    phase_idx = '0;
    if (running) begin
      phase     = {{(NUM_PHASES - 1){1'b0}}, 1'b1} << idx_q;
      phase_idx = idx_q;
    end
    lap_done  = lap_done_q;
    lap_count = lap_q;
    fault     = (state_q == S_FAULT);
    state_dbg = state_q;
  end

`ifdef PHASE_RING_ASSERT_EN
  // Tracks consecutive +1 steps so the cover can see a 0..N-1 walk.
  logic [IDX_W-1:0] cov_prev_q;
  int               cov_hops_q;

  // Hop counter for the full-lap cover point.
  always_ff @(posedge clock) begin
    cov_prev_q <= phase_idx;
    if (reset || !running) begin
      cov_hops_q <= 0;
    end else if (phase_idx != cov_prev_q) begin
      if (phase_idx == wrap_add(cov_prev_q, 1) && phase_idx != '0)
        cov_hops_q <= cov_hops_q + 1;
      else
        cov_hops_q <= 0;
    end
  end

  default clocking cb @(posedge clock); endclocking
  default disable iff (reset);

  a_onehot0: assert property ($onehot0(phase));
  a_run_iff: assert property ((phase != '0) == running);
  a_lapd_run: assert property (lap_done |-> running);
  a_fault_sticky: assert property (fault |=> fault);

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_order
    a_order: assert property (
      (skip_mask == '0 && phase[k] && ack[k] && enable)
        |=> (!phase[k] || NUM_PHASES == 1) && phase[(k + 1) % NUM_PHASES]);
  end

  c_full_lap: cover property (
    running && phase_idx == IDX_W'(NUM_PHASES - 1) && cov_hops_q == NUM_PHASES - 1
      ##1 (lap_done && phase_idx == '0));
`endif

endmodule

// File: tb/tb_phase_ring.sv
// tb_phase_ring: directed table of per-cycle {inputs, expected outputs}
// records, followed by hand-written watchdog, lap-wrap and reset sequences.
module tb_phase_ring;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  skip_mask;
  logic [N-1:0]  ack;
  logic [N-1:0]  phase;
  logic [1:0]    phase_idx;
  logic          running;
  logic          lap_done;
  logic [CW-1:0] lap_count;
  logic          fault;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [CW-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] mask;
    logic [N-1:0] ack;
    logic [N-1:0] ph;
    logic [1:0]   idx;
    logic         run;
    logic         ld;
    logic [CW-1:0] lc;
    logic         flt;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  phase_ring #(.NUM_PHASES(N), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .skip_mask (skip_mask),
    .ack       (ack),
    .phase     (phase),
    .phase_idx (phase_idx),
    .running   (running),
    .lap_done  (lap_done),
    .lap_count (lap_count),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic [N-1:0] m,
                       input logic [N-1:0] a);
    reset     = r;
    enable    = e;
    skip_mask = m;
    ack       = a;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [N-1:0] ph,
                               input logic [1:0] idx, input logic run,
                               input logic ld, input logic [CW-1:0] lc,
                               input logic flt);
    check({tag, ".phase"},     32'(phase),     32'(ph));
    check({tag, ".phase_idx"}, 32'(phase_idx), 32'(idx));
    check({tag, ".running"},   32'(running),   32'(run));
    check({tag, ".lap_done"},  32'(lap_done),  32'(ld));
    check({tag, ".lap_count"}, 32'(lap_count), 32'(lc));
    check({tag, ".fault"},     32'(fault),     32'(flt));
  endtask

  task automatic do_reset(input string tag);
    drive(1'b1, 1'b0, '0, '0);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check_outputs(tag, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic vadd(input logic r, input logic e, input logic [N-1:0] m,
                      input logic [N-1:0] a, input logic [N-1:0] ph,
                      input logic [1:0] idx, input logic run, input logic ld,
                      input logic [CW-1:0] lc);
    vec_t v;
    v.rst = r; v.en = e; v.mask = m; v.ack = a;
    v.ph = ph; v.idx = idx; v.run = run; v.ld = ld; v.lc = lc; v.flt = 1'b0;
    vecs.push_back(v);
  endtask

  // ---------------- safety timeout ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- main sequence ----------------
  initial begin
    drive(1'b1, 1'b0, '0, '0);
    @(negedge clock);
    do_reset("init_reset");

    // Each row: outputs expected this cycle, inputs applied for the next edge.
    //    rst  en  mask     ack      phase    idx  run ld lc
    // Full ring, ack every second cycle, one lap.
    vadd(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0001, 4'b0001, 0, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0010, 4'b0010, 1, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0000, 4'b0100, 2, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0100, 4'b0100, 2, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0000, 4'b1000, 3, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b1000, 4'b1000, 3, 1, 0, 0);
    vadd(0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, 1, 1);
    vadd(1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 1, 0, 1);   // reset mid-phase
    // Skip phases 1 and 2, ack every cycle.
    vadd(0, 1, 4'b0110, 4'b0000, 4'b0000, 0, 0, 0, 0);
    vadd(0, 1, 4'b0110, 4'b0001, 4'b0001, 0, 1, 0, 0);
    vadd(0, 1, 4'b0110, 4'b1000, 4'b1000, 3, 1, 0, 0);
    vadd(0, 1, 4'b0110, 4'b0001, 4'b0001, 0, 1, 1, 1);
    vadd(0, 1, 4'b0110, 4'b1000, 4'b1000, 3, 1, 0, 1);
    vadd(0, 1, 4'b0110, 4'b0000, 4'b0001, 0, 1, 1, 2);
    vadd(0, 1, 4'b0110, 4'b1110, 4'b0001, 0, 1, 0, 2);   // non-current acks
    vadd(0, 1, 4'b1111, 4'b0001, 4'b0001, 0, 1, 0, 2);   // all masked -> IDLE
    vadd(0, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 2);   // stays IDLE
    vadd(0, 1, 4'b1101, 4'b0000, 4'b0000, 0, 0, 0, 2);   // enter at idx 1
    // Single unmasked phase re-selects itself and counts a lap.
    vadd(0, 1, 4'b1101, 4'b0010, 4'b0010, 1, 1, 0, 2);
    vadd(0, 1, 4'b1111, 4'b0000, 4'b0010, 1, 1, 1, 3);   // mask current mid-wait
    vadd(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 3);
    vadd(0, 1, 4'b0000, 4'b0010, 4'b0010, 1, 1, 0, 3);
    // Drop enable in phase 2, ack three cycles later.
    vadd(0, 0, 4'b0000, 4'b0000, 4'b0100, 2, 1, 0, 3);
    vadd(0, 0, 4'b0000, 4'b0000, 4'b0100, 2, 1, 0, 3);
    vadd(0, 0, 4'b0000, 4'b0000, 4'b0100, 2, 1, 0, 3);
    vadd(0, 0, 4'b0000, 4'b0100, 4'b0100, 2, 1, 0, 3);
    vadd(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 3);
    // Lap counter wrap (2-bit) with only phase 0 active, then reset mid-run.
    vadd(0, 1, 4'b1110, 4'b0000, 4'b0000, 0, 0, 0, 3);
    vadd(0, 1, 4'b1110, 4'b0001, 4'b0001, 0, 1, 0, 3);
    vadd(0, 1, 4'b1110, 4'b0001, 4'b0001, 0, 1, 1, 0);
    vadd(0, 1, 4'b1110, 4'b0001, 4'b0001, 0, 1, 1, 1);
    vadd(0, 1, 4'b1110, 4'b0000, 4'b0001, 0, 1, 1, 2);
    vadd(1, 1, 4'b1110, 4'b0000, 4'b0001, 0, 1, 0, 2);
    vadd(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      check_outputs($sformatf("vec%0d", i), vecs[i].ph, vecs[i].idx,
                    vecs[i].run, vecs[i].ld, vecs[i].lc, vecs[i].flt);
      drive(vecs[i].rst, vecs[i].en, vecs[i].mask, vecs[i].ack);
      step();
    end

    // Five full laps over all four phases; lap_count wraps in 2 bits.
    do_reset("laps_reset");
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    drive(1'b0, 1'b1, '0, '0);
    step();
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (lap_done) begin
        logic [CW-1:0] exp_lc;
        exp_lc = exp_q.pop_front();
        check($sformatf("lap%0d.lap_count", 5 - exp_q.size()),
              32'(lap_count), 32'(exp_lc));
        check("lap.phase_at_wrap", 32'(phase), 32'(4'b0001));
      end
      drive(1'b0, 1'b1, '0, phase);
      step();
    end
    check("laps_outstanding", 32'(exp_q.size()), 32'd0);

    // Watchdog expiry: 17 RUN cycles without ack, then FAULT.
    do_reset("wd_reset");
    drive(1'b0, 1'b1, '0, '0);
    step();
    for (int c = 1; c <= TO + 1; c++) begin
      check($sformatf("wd_run%0d.fault_running", c), 32'({fault, running}), 32'b01);
      step();
    end
    check_outputs("wd_fault", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, '0, 4'b1111);
      step();
      check_outputs($sformatf("wd_sticky%0d", c), 4'b0000, 2'd0, 1'b0, 1'b0,
                    2'd0, 1'b1);
    end
    do_reset("wd_clear");

    // Ack arriving in the very cycle the watchdog reaches TIMEOUT.
    drive(1'b0, 1'b1, '0, '0);
    step();
    for (int c = 1; c <= TO; c++) step();
    check_outputs("race_pre", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, '0, 4'b0001);
    step();
    check_outputs("race_post", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b1, '0, '0);
    step();
    check_outputs("race_hold", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_ring.md
Name: phase_ring

Overview:
- Parametrised N-phase cyclic sequencer: one-hot phase token walks channels 0..N-1 in order, each phase held until acknowledged by its ack bit.
- Successor to the fixed four-signal A→B→C→D→A ring. Adds:
  - configurable phase count
  - runtime phase skipping
  - lap counting
  - per-phase watchdog timeout with fault state
- Serves as a demo/DUT for the team's formal flows and as a reusable round-robin phase controller.

Parameters:
- NUM_PHASES, 4, number of phases; legal range ≥2.
- TIMEOUT, 16, max cycles a phase may wait for ack; 0 disables the watchdog.
- CNT_W, 8, lap counter width.
- IDX_W, $clog2(NUM_PHASES), phase index width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request.
- skip_mask  in  NUM_PHASES  bit i=1 → phase i skipped when choosing the next phase.
- ack  in  NUM_PHASES  per-phase completion; only the bit of the current phase is honoured.
- phase  out  NUM_PHASES  one-hot current phase; all-zero when not running.
- phase_idx  out  IDX_W  binary index of current phase; 0 when not running.
- running  out  1  high in RUN.
- lap_done  out  1  one-cycle pulse on wrap.
- lap_count  out  CNT_W  completed laps, modulo 2^CNT_W.
- fault  out  1  sticky watchdog fault.

Behaviour:
- Reset is synchronous, active-high, and wins over every other input.
  - Reset values: state=IDLE, phase=0, phase_idx=0, running=0, lap_done=0, lap_count=0, fault=0, watchdog=0.
  - Reset mid-run aborts immediately; the next cycle shows reset values.
- States: IDLE, RUN, FAULT.
- Next-phase search:
  - From current index i, take the first index j in i+1, i+2, … (mod N) with skip_mask[j]=0.
  - The search includes i itself as the last candidate.
  - skip_mask is sampled only in the cycle the search is evaluated.
- IDLE:
  - If enable=1 and skip_mask is not all-ones, move to RUN next cycle at the lowest unmasked index.
  - Otherwise stay in IDLE.
  - lap_done is not pulsed on entry.
- RUN:
  - phase = 1<<phase_idx and running=1.
  - If ack[phase_idx]=1 and enable=1:
    - If an unmasked j exists: next cycle phase_idx=j and watchdog clears.
      - If j≤i (wrap, including a single unmasked phase re-selecting itself): lap_done=1 that same next cycle and lap_count increments, wrapping to 0 after 2^CNT_W−1.
    - If skip_mask is all-ones: go to IDLE with no lap increment.
  - If ack[phase_idx]=1 and enable=0: go to IDLE next cycle with no lap increment.
  - Deasserting enable never truncates a phase; the phase is held until acked.
  - Acks on non-current bits are ignored.
  - Masking the current phase mid-wait does not drop it.
- Latency: ack → phase change is exactly 1 cycle. One phase advance per cycle maximum.
- Watchdog (TIMEOUT>0):
  - Increments each RUN cycle without a current ack.
  - When it reaches TIMEOUT with no ack in that cycle, go to FAULT next cycle.
  - If ack and expiry occur in the same cycle, ack wins and no fault is raised.
- FAULT:
  - phase=0, running=0, fault=1.
  - Ignores enable and ack.
  - Only reset exits FAULT.
- Invariants:
  - phase is onehot0.
  - phase is non-zero iff running.
  - lap_done only when running.

Optional Feature:
- Macro: PHASE_RING_ASSERT_EN.
- Defined: the module embeds concurrent SVA with a default clocking on posedge clock and default disable iff (reset). Properties:
  - assert onehot0(phase)
  - assert phase!=0 ↔ running
  - assert that, with skip_mask=0, phase[k] is followed by !phase[k] throughout until phase[(k+1)%N], for every k (generate loop)
  - assert fault is sticky
  - cover one full lap 0→1→…→N-1→0
- Undefined: no properties are compiled, and the RTL behaviour is identical.

Test Plan:
- Reset, enable=1, skip_mask=0, N=4, ack the current phase every 2nd cycle → phase sequence 0001,0010,0100,1000,0001; lap_done pulses once on the return to 0001; lap_count=1.
- skip_mask=4'b0110, ack every cycle → phase_idx 0,3,0,3; lap_done on each return to 0; lap_count=2 after 4 acks.
- TIMEOUT=16, enter RUN, never ack → fault=1 and phase=0 after 17 RUN cycles (1 cycle after the count reaches 16); ack afterwards has no effect until reset.
- Ack asserted in the exact cycle the watchdog reaches TIMEOUT → advance to the next phase, fault stays 0.
- Drop enable while in phase 2, ack 3 cycles later → phase holds 0100 until the ack, then IDLE with phase=0 and no lap_done.
- CNT_W=2, 5 full laps → lap_count sequence 1,2,3,0,1; assert reset mid-phase → next cycle all outputs at reset values.
